// File: rtl/al_accel_pkg.sv
// Shared state encoding and data constants for the al_accel input feeder.
package al_accel_pkg;

  localparam int AL_ACCEL_NWEIGHT = 9;
  localparam int AL_ACCEL_DW      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } ifeed_state_t;

endpackage

// File: rtl/al_accel_ifeed_if.sv
// Byte-stream input and PU-facing weight/column outputs of the feeder.
// master = feeder side, slave = stream source / PU side.
interface al_accel_ifeed_if;
  import al_accel_pkg::*;

  logic                   s_valid;
  logic                   s_ready;
  logic [AL_ACCEL_DW-1:0] s_data;

  logic [AL_ACCEL_DW-1:0] pu_wdi_0_0, pu_wdi_0_1, pu_wdi_0_2;
  logic [AL_ACCEL_DW-1:0] pu_wdi_1_0, pu_wdi_1_1, pu_wdi_1_2;
  logic [AL_ACCEL_DW-1:0] pu_wdi_2_0, pu_wdi_2_1, pu_wdi_2_2;
  logic [AL_ACCEL_DW-1:0] pu_idi_0, pu_idi_1, pu_idi_2;
  logic                   pu_enb;
  logic                   pu_ready;

  modport master (
    input  s_valid, s_data, pu_ready,
    output s_ready,
    output pu_wdi_0_0, pu_wdi_0_1, pu_wdi_0_2,
    output pu_wdi_1_0, pu_wdi_1_1, pu_wdi_1_2,
    output pu_wdi_2_0, pu_wdi_2_1, pu_wdi_2_2,
    output pu_idi_0, pu_idi_1, pu_idi_2, pu_enb
  );

  modport slave (
    output s_valid, s_data, pu_ready,
    input  s_ready,
    input  pu_wdi_0_0, pu_wdi_0_1, pu_wdi_0_2,
    input  pu_wdi_1_0, pu_wdi_1_1, pu_wdi_1_2,
    input  pu_wdi_2_0, pu_wdi_2_1, pu_wdi_2_2,
    input  pu_idi_0, pu_idi_1, pu_idi_2, pu_enb
  );

endinterface

// File: rtl/al_accel_linebuf.sv
// One image row of pixels: same-address read/write, read returns the old word combinationally.
module al_accel_linebuf
  import al_accel_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_addr,
  input  logic [AL_ACCEL_DW-1:0] i_wdata,
  output logic [AL_ACCEL_DW-1:0] o_rdata
);

  logic [AL_ACCEL_DW-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Row storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/al_accel_ifeed.sv
// Feeder for al_accel_pu: latches nine weights, then streams 3-pixel columns from two line buffers.
// Optional top zero padding is enabled by defining AL_ACCEL_IFEED_ZPAD_EN.
module al_accel_ifeed
  import al_accel_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int CW    = $clog2(IMG_W + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [CW-1:0]   cfg_width,
  input  logic [CW-1:0]   cfg_height,
  output logic            busy,
  output logic            frame_done,
  al_accel_ifeed_if.master bus
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  ifeed_state_t           r_state, w_state_nxt;
  logic [CW-1:0]          r_width, r_height, r_col, r_row;
  logic [3:0]             r_wcnt;
  logic [AL_ACCEL_DW-1:0] r_wt [AL_ACCEL_NWEIGHT];
  logic [AL_ACCEL_DW-1:0] r_idi_0, r_idi_1, r_idi_2;
  logic                   r_enb, r_done;

  logic                   w_s_ready, w_acc, w_pix_acc, w_col_load, w_emit;
  logic                   w_last_col, w_last_row;
  logic [AL_ACCEL_DW-1:0] w_lb0_rd, w_lb1_rd, w_top, w_mid;

  assign w_s_ready  = ((r_state == LOAD_W) || (r_state == STREAM)) && (!r_enb || bus.pu_ready);
  assign w_acc      = bus.s_valid && w_s_ready;
  assign w_pix_acc  = w_acc && (r_state == STREAM);
  assign w_last_col = (r_col == r_width - CW'(1));
  assign w_last_row = (r_row == r_height - CW'(1));

`ifdef AL_ACCEL_IFEED_ZPAD_EN
  assign w_emit = 1'b1;
`else
  assign w_emit = (r_row >= CW'(2));
`endif

  // Rows above the image read as zero; stale buffer data never leaks into a frame.
  assign w_top      = (r_row >= CW'(2)) ? w_lb0_rd : '0;
  assign w_mid      = (r_row >= CW'(1)) ? w_lb1_rd : '0;
  assign w_col_load = w_pix_acc && w_emit;

  al_accel_linebuf #(.DEPTH(IMG_W), .AW(AW)) lb0 (
    .clk     (clk),
    .i_we    (w_pix_acc),
    .i_addr  (r_col[AW-1:0]),
    .i_wdata (w_lb1_rd),
    .o_rdata (w_lb0_rd)
  );

  al_accel_linebuf #(.DEPTH(IMG_W), .AW(AW)) lb1 (
    .clk     (clk),
    .i_we    (w_pix_acc),
    .i_addr  (r_col[AW-1:0]),
    .i_wdata (bus.s_data),
    .o_rdata (w_lb1_rd)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LOAD_W;
        else       w_state_nxt = IDLE;
      end
      LOAD_W: begin
        if (w_acc && (r_wcnt == 4'(AL_ACCEL_NWEIGHT - 1))) w_state_nxt = STREAM;
        else                                                w_state_nxt = LOAD_W;
      end
      STREAM: begin
        if (w_acc && w_last_col && w_last_row) w_state_nxt = DONE;
        else                                   w_state_nxt = STREAM;
      end
      DONE: begin
        if (!r_enb) w_state_nxt = IDLE;
        else        w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Config, counters, weights, column register and completion pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_width  <= '0;
      r_height <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_wcnt   <= 4'd0;
      for (int i = 0; i < AL_ACCEL_NWEIGHT; i++) r_wt[i] <= '0;
      r_idi_0  <= '0;
      r_idi_1  <= '0;
      r_idi_2  <= '0;
      r_enb    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_width  <= cfg_width;
            r_height <= cfg_height;
            r_wcnt   <= 4'd0;
            r_col    <= '0;
            r_row    <= '0;
          end
        end
        LOAD_W: begin
          if (w_acc) begin
            for (int i = 0; i < AL_ACCEL_NWEIGHT; i++) begin
              if (r_wcnt == 4'(i)) r_wt[i] <= bus.s_data;
            end
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
        STREAM: begin
          if (w_acc) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + CW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        DONE: begin
          if (!r_enb) r_done <= 1'b1;
        end
        default: r_done <= 1'b0;
      endcase

      if (w_col_load) begin
        r_idi_0 <= w_top;
        r_idi_1 <= w_mid;
        r_idi_2 <= bus.s_data;
        r_enb   <= 1'b1;
      end else if (r_enb && bus.pu_ready) begin
        r_enb <= 1'b0;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign frame_done = r_done;

  assign bus.s_ready    = w_s_ready;
  assign bus.pu_enb     = r_enb;
  assign bus.pu_idi_0   = r_idi_0;
  assign bus.pu_idi_1   = r_idi_1;
  assign bus.pu_idi_2   = r_idi_2;
  assign bus.pu_wdi_0_0 = r_wt[0];
  assign bus.pu_wdi_0_1 = r_wt[1];
  assign bus.pu_wdi_0_2 = r_wt[2];
  assign bus.pu_wdi_1_0 = r_wt[3];
  assign bus.pu_wdi_1_1 = r_wt[4];
  assign bus.pu_wdi_1_2 = r_wt[5];
  assign bus.pu_wdi_2_0 = r_wt[6];
  assign bus.pu_wdi_2_1 = r_wt[7];
  assign bus.pu_wdi_2_2 = r_wt[8];

endmodule

// File: tb/tb_al_accel_ifeed.sv
// Scoreboard bench for al_accel_ifeed: directed frames push expected columns, a monitor pops on each PU transfer.
module tb_al_accel_ifeed;

  localparam int CW = 6;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [CW-1:0] cfg_width;
  logic [CW-1:0] cfg_height;
  logic          busy;
  logic          frame_done;

  al_accel_ifeed_if bus ();

  al_accel_ifeed #(.IMG_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          enb_cnt = 0;
  bit          stall_seen = 1'b0;
  logic [23:0] exp_q [$];
  int          pop_cyc [$];
  logic [23:0] mon_exp;
  logic [23:0] mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts pulses and compares every transferred column against the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_done) done_cnt++;
      if (bus.pu_enb) enb_cnt++;
      if (bus.pu_enb && bus.pu_ready) begin
        mon_act = {bus.pu_idi_0, bus.pu_idi_1, bus.pu_idi_2};
        pop_cyc.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL column_unexpected act=%h req=none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            bad++;
            $display("FAIL column act=%h req=%h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic push_col(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    exp_q.push_back({t, m, b});
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n != 0) stall_seen = 1'b1;
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout act=stalled req=accept data=%0h", b);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [CW-1:0] w, input logic [CW-1:0] h);
    cfg_width  = w;
    cfg_height = h;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", {71'd0, busy}, 72'd1);
    check("s_ready_after_start", {71'd0, bus.s_ready}, 72'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights();
    stall_seen = 1'b0;
    send(8'hF6); send(8'h40); send(8'h55);
    send(8'h0D); send(8'h88); send(8'hA5);
    send(8'h14); send(8'h11); send(8'h9C);
    @(negedge clk);
    check("w_0_0", {64'd0, bus.pu_wdi_0_0}, 72'hF6);
    check("w_0_1", {64'd0, bus.pu_wdi_0_1}, 72'h40);
    check("w_1_1", {64'd0, bus.pu_wdi_1_1}, 72'h88);
    check("w_2_2", {64'd0, bus.pu_wdi_2_2}, 72'h9C);
    check("w_no_stall", {71'd0, stall_seen}, 72'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frame_done_seen", 72'(done_cnt), 72'(target));
    repeat (2) @(negedge clk);
    check("frame_done_single", 72'(done_cnt), 72'(target));
    check("idle_busy", {71'd0, busy}, 72'd0);
    check("idle_enb", {71'd0, bus.pu_enb}, 72'd0);
    check("sb_empty", 72'(exp_q.size()), 72'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {68'd0, bus.pu_enb, bus.s_ready, busy, frame_done}, 72'd0);
    check({tag, "_idi"}, {48'd0, bus.pu_idi_0, bus.pu_idi_1, bus.pu_idi_2}, 72'd0);
    check({tag, "_wdi"}, {bus.pu_wdi_0_0, bus.pu_wdi_0_1, bus.pu_wdi_0_2,
                          bus.pu_wdi_1_0, bus.pu_wdi_1_1, bus.pu_wdi_1_2,
                          bus.pu_wdi_2_0, bus.pu_wdi_2_1, bus.pu_wdi_2_2}, 72'd0);
  endtask

  // Width 4, height 3, pixels 1..12; optional 3-cycle stall while column 2 is presented.
  task automatic frame_4x3(input bit bp);
    int d0;
    d0 = done_cnt;
    pop_cyc.delete();
    start_frame(6'd4, 6'd3);
    load_weights();
`ifdef AL_ACCEL_IFEED_ZPAD_EN
    push_col(8'd0, 8'd0, 8'd1); push_col(8'd0, 8'd0, 8'd2);
    push_col(8'd0, 8'd0, 8'd3); push_col(8'd0, 8'd0, 8'd4);
    push_col(8'd0, 8'd1, 8'd5); push_col(8'd0, 8'd2, 8'd6);
    push_col(8'd0, 8'd3, 8'd7); push_col(8'd0, 8'd4, 8'd8);
`endif
    push_col(8'd1, 8'd5, 8'd9);  push_col(8'd2, 8'd6, 8'd10);
    push_col(8'd3, 8'd7, 8'd11); push_col(8'd4, 8'd8, 8'd12);
    for (int p = 1; p <= 12; p++) begin
      send(8'(p));
      if (bp && p == 10) begin
        bus.pu_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_hold", {48'd0, bus.pu_idi_0, bus.pu_idi_1, bus.pu_idi_2}, 72'h02060A);
          check("bp_enb", {71'd0, bus.pu_enb}, 72'd1);
          check("bp_s_ready", {71'd0, bus.s_ready}, 72'd0);
          @(posedge clk);
          #1;
        end
        bus.pu_ready = 1'b1;
      end
    end
    wait_done(d0 + 1);
    if (!bp) begin
`ifdef AL_ACCEL_IFEED_ZPAD_EN
      check("col_count", 72'(pop_cyc.size()), 72'd12);
`else
      check("col_count", 72'(pop_cyc.size()), 72'd4);
`endif
      check("col_back_to_back", 72'(pop_cyc[pop_cyc.size()-1] - pop_cyc[0]), 72'(pop_cyc.size() - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1);
  end

  initial begin
    int d0;
    int e0;
    resetn       = 1'b0;
    start        = 1'b0;
    cfg_width    = '0;
    cfg_height   = '0;
    bus.s_valid  = 1'b0;
    bus.s_data   = 8'd0;
    bus.pu_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;

    frame_4x3(1'b0);
    frame_4x3(1'b1);

    // Reset mid-frame after five pixels, then the basic frame again.
    start_frame(6'd4, 6'd3);
    load_weights();
`ifdef AL_ACCEL_IFEED_ZPAD_EN
    push_col(8'd0, 8'd0, 8'd1); push_col(8'd0, 8'd0, 8'd2);
    push_col(8'd0, 8'd0, 8'd3); push_col(8'd0, 8'd0, 8'd4);
`endif
    for (int p = 1; p <= 5; p++) send(8'(p));
    resetn = 1'b0;
    #2;
    check_zero("midreset");
    check("midreset_sb", 72'(exp_q.size()), 72'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    frame_4x3(1'b0);

    // Width-1 frame with a stray start while streaming.
    d0 = done_cnt;
`ifdef AL_ACCEL_IFEED_ZPAD_EN
    push_col(8'd0, 8'd0, 8'd4); push_col(8'd0, 8'd4, 8'd5);
`endif
    push_col(8'd4, 8'd5, 8'd6);
    start_frame(6'd1, 6'd3);
    load_weights();
    send(8'd4);
    cfg_width  = 6'd7;
    cfg_height = 6'd9;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("stray_start_busy", {71'd0, busy}, 72'd1);
    send(8'd5);
    send(8'd6);
    wait_done(d0 + 1);

`ifdef AL_ACCEL_IFEED_ZPAD_EN
    d0 = done_cnt;
    push_col(8'd0, 8'd0, 8'd7);  push_col(8'd0, 8'd0, 8'h80);
    push_col(8'd0, 8'd7, 8'd12); push_col(8'd0, 8'h80, 8'd5);
    start_frame(6'd2, 6'd2);
    load_weights();
    send(8'd7); send(8'h80); send(8'd12); send(8'd5);
    wait_done(d0 + 1);
`else
    d0 = done_cnt;
    e0 = enb_cnt;
    start_frame(6'd3, 6'd2);
    load_weights();
    send(8'd1); send(8'd2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int p = 3; p <= 6; p++) send(8'(p));
    wait_done(d0 + 1);
    check("short_no_enb", 72'(enb_cnt - e0), 72'd0);
`endif

    repeat (3) @(negedge clk);
    check("final_sb_empty", 72'(exp_q.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/al_accel_ifeed.md
# al_accel_ifeed

Input feeder for the 3x3 processing unit `al_accel_pu`. It accepts one byte stream carrying nine signed weights followed by a row-major image. It holds the weights stable on the nine `pu_wdi_r_c` outputs. It buffers two image rows and presents one vertical 3-pixel column per accepted pixel on `pu_idi_0..2`, qualified by `pu_enb`. It sits directly upstream of the PU, between the DMA/stream source and the PU.

## Interface
- `IMG_W`, 32: maximum image width in pixels (line-buffer depth).
- `CW`, `$clog2(IMG_W+1)`: width of the column/row counters and `cfg_*` ports.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a frame; sampled only in IDLE.
- `cfg_width` in CW: image width, 1..IMG_W; sampled on `start`.
- `cfg_height` in CW: image height, >=1; sampled on `start`.
- `s_valid` in 1: stream byte valid.
- `s_ready` out 1: stream byte accepted when `s_valid & s_ready`.
- `s_data` in 8: signed byte; nine weights first, then the pixels.
- `pu_wdi_0_0 .. pu_wdi_2_2` out 8 each: held weights, row-major.
- `pu_idi_0`, `pu_idi_1`, `pu_idi_2` out 8 each: column from row r-2, r-1, r (top to bottom).
- `pu_enb` out 1: column valid.
- `pu_ready` in 1: PU consumes the column when `pu_enb & pu_ready`.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_done` out 1: one-cycle pulse at the end of a frame.

## Operation
- States are IDLE, LOAD_W, STREAM, DONE.
- IDLE -> LOAD_W on `start`. The block latches `cfg_width`/`cfg_height` and clears `wcnt`, `col` and `row`.
- LOAD_W:
  - Each accepted byte goes to weight register `wcnt`, row-major 0_0, 0_1, … 2_2.
  - The ninth accept moves the state to STREAM.
- STREAM:
  - Each accepted pixel `p` at (`row`, `col`) reads `lb1[col]` (row-1) and `lb0[col]` (row-2).
  - It then writes `lb0[col] <= lb1[col]` and `lb1[col] <= p`.
  - `col` wraps at `cfg_width-1` and `row` then increments.
- Column output: when `row >= 2`, the output register loads `{lb0[col], lb1[col], p}` and `pu_enb` is set.
- Frame end: the accept at (`cfg_height-1`, `cfg_width-1`) moves the state to DONE.
- DONE:
  - Waits until `pu_enb` is low, i.e. the last column has been consumed.
  - Pulses `frame_done` for one cycle, then returns to IDLE.
- `s_ready = (state==LOAD_W || state==STREAM) && (!pu_enb || pu_ready)`. Backpressure from the PU therefore stalls the stream.
- `pu_enb` clears on a transfer (`pu_enb & pu_ready`) unless a new column loads in the same cycle.
- While `pu_enb & !pu_ready`, all `pu_idi_*` outputs hold.
- Weights hold through DONE and IDLE until the next frame's LOAD_W overwrites them.
- The block performs no arithmetic on data. Bytes pass through bit-exact as signed 8-bit values.
- Boundary conditions:
  - `start` outside IDLE is ignored.
  - `cfg_height < 3` without padding: the block consumes all pixels, emits no columns and still pulses `frame_done`.
  - `cfg_width == 1` is legal.
  - `resetn` low mid-frame: state returns to IDLE immediately. Weights, outputs and counters clear; line-buffer contents are don't-care.

## Timing
- Reset values:
  - All `pu_wdi_*` and `pu_idi_*` outputs are 0.
  - `pu_enb`, `s_ready`, `busy` and `frame_done` are 0.
  - State is IDLE.
- `busy` rises the cycle after `start`.
- `s_ready` rises the cycle after `start`, provided `pu_enb` is 0.
- Column latency is 1 cycle: the pixel is accepted at edge N and `pu_enb`/`pu_idi_*` are valid after edge N.
- Throughput with `pu_ready` held high is one column per cycle, with no bubbles at row wrap.
- Weights are valid the cycle after the ninth weight is accepted.
- `frame_done` is asserted 1 cycle after DONE is entered with `pu_enb` low.

## Configuration
- `AL_ACCEL_IFEED_ZPAD_EN` defined: top zero padding.
  - A column is emitted for every accepted pixel, from row 0 onward.
  - Rows above the image read as 0. Row 0 emits (0,0,p); row 1 emits (0,lb1,p).
- `AL_ACCEL_IFEED_ZPAD_EN` undefined: columns are emitted only for `row >= 2`, as described in Operation.

## Structure
- Package `al_accel_pkg` holds:
  - The state enum `ifeed_state_t` (IDLE/LOAD_W/STREAM/DONE).
  - The constants `AL_ACCEL_NWEIGHT=9` and `AL_ACCEL_DW=8`.
- Sub-module `al_accel_linebuf`:
  - Depth IMG_W, 8-bit, one read and one write at the same address per cycle.
  - Reads return old data, combinationally.
  - Instantiated twice (`lb0`, `lb1`).

## Test plan
- Weight load:
  - Stimulus: `start`, then stream -10, 64, 85, 13, -120, -91, 20, 17, -100.
  - Response: `pu_wdi_0_0`=0xF6, `pu_wdi_1_1`=0x88, `pu_wdi_2_2`=0x9C; `s_ready` stays high.
- Basic frame:
  - Stimulus: width 4, height 3, pixels 1..12, `pu_ready`=1.
  - Response: exactly 4 columns (1,5,9), (2,6,10), (3,7,11), (4,8,12) on consecutive cycles, then `frame_done`.
- Backpressure:
  - Stimulus: same frame, `pu_ready` held low for 3 cycles on column 2.
  - Response: (2,6,10) holds, `s_ready`=0, no loss and no duplicate.
- ZPAD (`AL_ACCEL_IFEED_ZPAD_EN` defined):
  - Stimulus: width 2, height 2, pixels 7, -128, 12, 5.
  - Response: columns (0,0,7), (0,0,-128), (0,7,12), (0,-128,5).
- Reset mid-frame:
  - Stimulus: drop `resetn` after 5 pixels.
  - Response: all outputs are 0 and state is IDLE. A new `start` followed by the basic frame reproduces the basic-frame results.
- Ignored start / short image:
  - Stimulus: `start` asserted in STREAM, then a frame with height 2 without ZPAD.
  - Response: the stray `start` has no effect; the height-2 frame produces zero `pu_enb` and one `frame_done`.
